// File: rtl/bram_fifo_fwft.sv
// First-word-fall-through FIFO over a synchronous-read block RAM with a two-stage prefetch (RAM read register + head register).
// Latency: a word written into an empty FIFO appears on D_OUT two edges after the enqueue edge; steady state is 1 word/cycle each way.
// Backpressure: FULL_N drops when COUNT reaches p2depth. ENQ while full and DEQ while empty are dropped and raise sticky OVF/UDF.
module bram_fifo_fwft #(
    parameter int p1width      = 32,
    parameter int p2depth      = 1024,
    parameter int p3cntr_width = 11,
    parameter int p4af_level   = 1020,
    parameter int p5ae_level   = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    CLR,
    input  logic [p1width-1:0]      D_IN,
    input  logic                    ENQ,
    input  logic                    DEQ,
    output logic [p1width-1:0]      D_OUT,
    output logic                    EMPTY_N,
    output logic                    FULL_N,
    output logic [p3cntr_width-1:0] COUNT,
    output logic                    ALMOST_FULL,
    output logic                    ALMOST_EMPTY,
    output logic                    OVF,
    output logic                    UDF
);

    localparam int AW = (p2depth > 1) ? $clog2(p2depth) : 1;
    localparam logic [AW-1:0]           LAST_PTR = AW'(p2depth - 1);
    localparam logic [p3cntr_width-1:0] DEPTH_C  = p3cntr_width'(p2depth);
    localparam logic [p3cntr_width-1:0] AF_C     = p3cntr_width'(p4af_level);
    localparam logic [p3cntr_width-1:0] AE_C     = p3cntr_width'(p5ae_level);

    // Storage and the RAM's own output register (no reset, so it maps onto block RAM).
    logic [p1width-1:0] mem_q [p2depth];
    logic [p1width-1:0] rd_dat_q;

    logic [AW-1:0]           wptr_q, wptr_d;
    logic [AW-1:0]           rptr_q, rptr_d;
    logic [p3cntr_width-1:0] count_q, count_d;
    logic                    rd_vld_q, rd_vld_d;     // rd_dat_q holds a prefetched word
    logic                    out_vld_q, out_vld_d;   // head register holds the word on D_OUT
    logic [p1width-1:0]      out_dat_q, out_dat_d;
    logic                    ovf_q, ovf_d;
    logic                    udf_q, udf_d;

    logic                    full_n;
    logic                    enq_ok;
    logic                    deq_ok;
    logic                    rd_moves;
    logic                    rd_en;
    logic [p3cntr_width-1:0] ram_words;

    assign full_n = (count_q < DEPTH_C);
    assign enq_ok = ENQ & full_n & ~CLR;
    assign deq_ok = DEQ & out_vld_q & ~CLR;

    // Words that sit in RAM and have not been read yet; COUNT also covers both prefetch stages.
    assign ram_words = count_q - p3cntr_width'(rd_vld_q) - p3cntr_width'(out_vld_q);

    // The prefetched word advances into the head register whenever the head is free or being retired.
    assign rd_moves = rd_vld_q & (~out_vld_q | deq_ok);

    // Issue a RAM read whenever the read register will be free after this edge. A word written at this
    // edge is not yet counted in ram_words, so the read and write addresses never collide.
    assign rd_en = ~CLR & (ram_words != '0) & (~rd_vld_q | rd_moves);

    // Block RAM write port and registered read port.
    always_ff @(posedge CLK) begin
        if (enq_ok) begin
            mem_q[wptr_q] <= D_IN;
        end
        if (rd_en) begin
            rd_dat_q <= mem_q[rptr_q];
        end
    end

    // Next-state for pointers, occupancy, prefetch stages and sticky error flags.
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        rd_vld_d  = rd_vld_q;
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;

        if (CLR) begin
            wptr_d    = '0;
            rptr_d    = '0;
            count_d   = '0;
            rd_vld_d  = 1'b0;
            out_vld_d = 1'b0;
            ovf_d     = 1'b0;
            udf_d     = 1'b0;
        end else begin
            if (enq_ok) begin
                wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
            end
            if (rd_en) begin
                rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
            end

            count_d = count_q + p3cntr_width'(enq_ok) - p3cntr_width'(deq_ok);

            if (~out_vld_q | deq_ok) begin
                out_vld_d = rd_vld_q;
                if (rd_vld_q) begin
                    out_dat_d = rd_dat_q;
                end
            end

            if (rd_en) begin
                rd_vld_d = 1'b1;
            end else if (rd_moves) begin
                rd_vld_d = 1'b0;
            end

            ovf_d = ovf_q | (ENQ & ~full_n);
            udf_d = udf_q | (DEQ & ~out_vld_q);
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            rd_vld_q  <= 1'b0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            rd_vld_q  <= rd_vld_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    assign D_OUT        = out_dat_q;
    assign EMPTY_N      = out_vld_q;
    assign FULL_N       = full_n;
    assign COUNT        = count_q;
    assign ALMOST_FULL  = (count_q >= AF_C);
    assign ALMOST_EMPTY = (count_q <= AE_C);
    assign OVF          = ovf_q;
    assign UDF          = udf_q;

endmodule

// File: doc/bram_fifo_fwft.md
BRAM_FIFO_FWFT -- requirements
Module: bram_fifo_fwft

Interface
REQ-001 SHALL have parameter p1width, default 32, data word width in bits (>=1).
REQ-002 SHALL have parameter p2depth, default 1024, total word capacity (>=2, any integer, not only power of two).
REQ-003 SHALL have parameter p3cntr_width, default 11, COUNT width; SHALL hold values 0..p2depth.
REQ-004 SHALL have parameter p4af_level, default 1020, almost-full threshold (1..p2depth).
REQ-005 SHALL have parameter p5ae_level, default 4, almost-empty threshold (0..p2depth-1).
REQ-006 CLK  input  1  sole clock, all state on rising edge.
REQ-007 RST  input  1  reset, asynchronous, active-high.
REQ-008 CLR  input  1  synchronous clear, active-high.
REQ-009 D_IN  input  p1width  enqueue data.
REQ-010 ENQ  input  1  enqueue request.
REQ-011 DEQ  input  1  dequeue request (acknowledges current D_OUT).
REQ-012 D_OUT  output  p1width  head word, valid while EMPTY_N=1 (first-word-fall-through).
REQ-013 EMPTY_N  output  1  head word present on D_OUT.
REQ-014 FULL_N  output  1  ENQ will be accepted.
REQ-015 COUNT  output  p3cntr_width  words held (memory plus prefetch stages).
REQ-016 ALMOST_FULL  output  1  COUNT >= p4af_level.
REQ-017 ALMOST_EMPTY  output  1  COUNT <= p5ae_level.
REQ-018 OVF  output  1  sticky: ENQ seen while FULL_N=0.
REQ-019 UDF  output  1  sticky: DEQ seen while EMPTY_N=0.

Function
REQ-020 Storage SHALL be a block-RAM array of p2depth words with synchronous (registered) read; no asynchronous read of the array.
REQ-021 Write and read pointers SHALL wrap from p2depth-1 to 0 explicitly.
REQ-022 ENQ with FULL_N=1 SHALL write D_IN and increment COUNT at that edge.
REQ-023 ENQ with FULL_N=0 SHALL be ignored (no write, pointers/COUNT unchanged) and set OVF.
REQ-024 DEQ with EMPTY_N=1 SHALL retire the head word and decrement COUNT at that edge.
REQ-025 DEQ with EMPTY_N=0 SHALL be ignored and set UDF.
REQ-026 Accepted ENQ and accepted DEQ in the same cycle SHALL leave COUNT unchanged, including the case where wptr==rptr.
REQ-027 FULL_N SHALL equal (COUNT < p2depth); ALMOST_FULL/ALMOST_EMPTY SHALL be functions of registered COUNT only.
REQ-028 Write-to-head latency: word accepted at edge k into an empty FIFO SHALL appear on D_OUT with EMPTY_N=1 after edge k+2; COUNT SHALL read 1 after edge k.
REQ-029 Prefetch logic SHALL refill the head from RAM so that back-to-back DEQ every cycle sustains 1 word/cycle while COUNT >= 2 words already past the 2-cycle latency.
REQ-030 Sustained ENQ every cycle with FULL_N=1 SHALL be accepted at 1 word/cycle.
REQ-031 D_OUT SHALL remain stable while EMPTY_N=1 and DEQ=0.
REQ-032 Word order SHALL be strict FIFO across pointer wrap.
REQ-033 CLR=1 SHALL at that edge empty the FIFO, zero pointers/COUNT, clear OVF/UDF, drop in-flight prefetch; same-cycle ENQ/DEQ ignored and not flagged.

Reset
REQ-034 RST=1 SHALL asynchronously force COUNT=0, EMPTY_N=0, FULL_N=1, ALMOST_FULL=0, ALMOST_EMPTY=1, OVF=0, UDF=0, pointers=0, prefetch stages invalid; RAM contents need not reset.
REQ-035 RST asserted mid-operation SHALL discard all stored and in-flight words; first ENQ after release behaves per REQ-028.
REQ-036 RST SHALL take priority over CLR.

Verification (p1width=8, p2depth=5, p4af_level=4, p5ae_level=1)
REQ-037 Reset then ENQ 0xA1 at edge 1 -> COUNT=1 after edge 1, EMPTY_N=1 and D_OUT=0xA1 after edge 3; DEQ -> COUNT=0, EMPTY_N=0.
REQ-038 ENQ 0x01..0x05 back-to-back -> FULL_N=0 and ALMOST_FULL=1 with COUNT=5; extra ENQ 0x06 -> OVF=1, COUNT stays 5; drain yields 0x01..0x05 one per cycle, 0x06 never appears.
REQ-039 Continuous ENQ+DEQ for 13 words 0x10..0x1C (pointers wrap twice at depth 5) -> output 0x10..0x1C in order, no gaps after initial latency, COUNT steady.
REQ-040 DEQ on empty FIFO -> UDF=1, COUNT=0, EMPTY_N stays 0; UDF stays 1 until CLR.
REQ-041 Load 3 words, assert CLR together with ENQ and DEQ -> COUNT=0, EMPTY_N=0, OVF=UDF=0 next cycle; next ENQ 0x77 emerges per REQ-028.
REQ-042 Load 4 words, assert RST for half a cycle between edges -> outputs at reset values immediately, before next CLK edge.
